axis_packet_fifo: RTL and testbench
===================================

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 Parameter DATA_W, default 16: tdata width in bits; legal range 1..512.
REQ-002 Parameter DEPTH, default 16: storage entries; power of two, minimum 2.
REQ-003 Parameter PACKET_MODE, default 0: 0 = word mode, 1 = store-and-forward on tlast.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port s_tvalid, input, 1: slave-side word valid.
REQ-007 Port s_tready, output, 1: slave-side ready.
REQ-008 Port s_tdata, input, DATA_W: slave-side data.
REQ-009 Port s_tlast, input, 1: slave-side end of packet.
REQ-010 Port m_tvalid, output, 1: master-side word valid.
REQ-011 Port m_tready, input, 1: master-side ready.
REQ-012 Port m_tdata, output, DATA_W: master-side data.
REQ-013 Port m_tlast, output, 1: master-side end of packet.
REQ-014 Port count, output, $clog2(DEPTH)+1: words currently stored.
REQ-015 Port pkt_count, output, $clog2(DEPTH)+1: complete packets (stored tlast words) currently held.

Function
REQ-016 A write occurs on a clock edge with s_tvalid && s_tready; a read occurs on a clock edge with m_tvalid && m_tready.
REQ-017 s_tready SHALL be 1 exactly when count < DEPTH; it SHALL NOT depend combinationally on m_tready.
REQ-018 A word and its tlast SHALL be stored together and emitted in write order, unmodified.
REQ-019 Latency: a word written into an empty FIFO at edge N SHALL be presented on m_tvalid/m_tdata after edge N, i.e. usable at edge N+1; there is no same-cycle bypass.
REQ-020 Once m_tvalid is asserted, m_tvalid, m_tdata and m_tlast SHALL remain stable until a read occurs.
REQ-021 count SHALL increment on a write without a read, decrement on a read without a write, and hold on both or neither.
REQ-022 pkt_count SHALL increment on a write with s_tlast=1 and decrement on a read with m_tlast=1; simultaneous events net to zero change.
REQ-023 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; full/empty SHALL be derived from count.
REQ-024 When full, a write is not accepted, even if a read occurs in the same cycle; s_tready rises the cycle after the read.
REQ-025 When empty, m_tvalid=0, even if a write occurs in the same cycle.
REQ-026 Word mode (PACKET_MODE=0): m_tvalid = (count > 0).
REQ-027 Packet mode (PACKET_MODE=1): m_tvalid SHALL be 1 when count > 0 and any of the following holds:
- pkt_count > 0;
- count == DEPTH (cut-through release, so a packet longer than DEPTH cannot deadlock);
- release is latched.
REQ-028 Release latch: set when the full cut-through condition of REQ-027 is met; cleared on a read with m_tlast=1. While set, the packet streams out word by word as in word mode.
REQ-029 count and pkt_count SHALL never exceed DEPTH or underflow; a read when empty and a write when full are not possible by construction.

Reset
REQ-030 While reset=1, asynchronously:
- count=0, pkt_count=0, read and write pointers=0, release latch=0;
- m_tvalid=0, s_tready=0;
- m_tdata and m_tlast are don't-care; the bench SHALL NOT check them.
REQ-031 On the first edge after reset deasserts, s_tready SHALL be 1; storage contents need not be cleared.
REQ-032 Reset asserted mid-packet SHALL discard all stored words; no partial packet is emitted afterwards.

Verification
REQ-033 Word mode, DEPTH=4, m_tready=1: write 1,2,3 (tlast on 3) on consecutive cycles -> outputs 1,2,3, each one cycle after its write, with tlast only on 3; count peaks at 1.
REQ-034 Word mode, DEPTH=4, m_tready=0: write 5 words -> s_tready drops after the 4th, count=4; then raise m_tready with s_tvalid held -> 5th word accepted the cycle after the first read; order preserved.
REQ-035 Packet mode, DEPTH=8: write 3 words (tlast on 3rd), one per cycle, m_tready=1 -> m_tvalid stays 0 until the edge after the tlast write, then 3 words emit back-to-back; pkt_count goes 1 -> 0.
REQ-036 Packet mode, DEPTH=4: write a 6-word packet with m_tready=1 -> on reaching count=4, output starts (release), all 6 words emerge in order, release clears after tlast; no deadlock.
REQ-037 Simultaneous read and write at count=2 for 10 cycles -> count stays 2, pointers wrap correctly, data order intact.
REQ-038 Assert reset for 1 cycle with count=3 mid-packet -> count=0, pkt_count=0, m_tvalid=0 immediately; a subsequent 2-word packet passes correctly.

Source files
------------

// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: AXI-Stream FIFO. In word mode each stored word is
// released as soon as it is stored. In packet mode words are held until
// a whole packet (tlast) is stored, with a cut-through escape when the
// FIFO fills so that packets longer than DEPTH cannot deadlock.
module axis_packet_fifo #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [DATA_W-1:0]      s_tdata,
    input  logic                   s_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tlast,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] pkt_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [AW-1:0] ONE_P    = AW'(1);

    // Each entry holds {tlast, tdata}
    logic [DATA_W:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            rel_latch;
    logic            full;
    logic            empty;
    logic            wr;
    logic            rd;
    logic            pkt_in;
    logic            pkt_out;
    logic [DATA_W:0] head;

    // Status flags, handshakes and output presentation
    always_comb begin
        full     = (count == FULL_CNT);
        empty    = (count == '0);
        head     = mem[rd_ptr];
        m_tdata  = head[DATA_W-1:0];
        m_tlast  = head[DATA_W];
        // Ready is forced low while reset is held, even though count is 0
        s_tready = !reset && !full;
        if (PACKET_MODE == 0) begin
            m_tvalid = !empty;
        end else begin
            m_tvalid = !empty && ((pkt_count != '0) || full || rel_latch);
        end
        wr      = s_tvalid && s_tready;
        rd      = m_tvalid && m_tready;
        pkt_in  = wr && s_tlast;
        pkt_out = rd && m_tlast;
    end

    // Storage write; contents are not cleared by reset
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= {s_tlast, s_tdata};
        end
    end

    // Pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + ONE_P;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
        end
    end

    // Word occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({wr, rd})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // Complete-packet occupancy (stored tlast words)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else begin
            case ({pkt_in, pkt_out})
                2'b10:   pkt_count <= pkt_count + ONE_C;
                2'b01:   pkt_count <= pkt_count - ONE_C;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // Cut-through latch: once full, stream the head packet until its tlast leaves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rel_latch <= 1'b0;
        end else if (PACKET_MODE == 0) begin
            rel_latch <= 1'b0;
        end else if (pkt_out) begin
            rel_latch <= 1'b0;
        end else if (full) begin
            rel_latch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: three instances (word DEPTH=4, packet DEPTH=8,
// packet DEPTH=4) share one stimulus stream; each is compared every cycle
// against a queue-based reference model, plus directed checks per scenario.
module tb_axis_packet_fifo;
    localparam int DW = 16;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] data;
        logic          last;
        logic          ready;
        logic [4:0]    cnt;
        logic [4:0]    pkt;
    } obs_t;

    typedef logic [DW:0] q_t[$];

    logic          clk = 1'b0;
    logic          reset;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          m_tready;

    logic          w_s_tready, w_m_tvalid, w_m_tlast;
    logic [DW-1:0] w_m_tdata;
    logic [2:0]    w_count, w_pkt;
    logic          a_s_tready, a_m_tvalid, a_m_tlast;
    logic [DW-1:0] a_m_tdata;
    logic [3:0]    a_count, a_pkt;
    logic          b_s_tready, b_m_tvalid, b_m_tlast;
    logic [DW-1:0] b_m_tdata;
    logic [2:0]    b_count, b_pkt;

    int total = 0;
    int bad   = 0;

    q_t q0, q1, q2;
    bit rel [3];

    always #5 clk = ~clk;

    axis_packet_fifo #(.DATA_W(DW), .DEPTH(4), .PACKET_MODE(0)) dut_w (
        .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tready(w_s_tready),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .m_tvalid(w_m_tvalid),
        .m_tready(m_tready), .m_tdata(w_m_tdata), .m_tlast(w_m_tlast),
        .count(w_count), .pkt_count(w_pkt));

    axis_packet_fifo #(.DATA_W(DW), .DEPTH(8), .PACKET_MODE(1)) dut_a (
        .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tready(a_s_tready),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .m_tvalid(a_m_tvalid),
        .m_tready(m_tready), .m_tdata(a_m_tdata), .m_tlast(a_m_tlast),
        .count(a_count), .pkt_count(a_pkt));

    axis_packet_fifo #(.DATA_W(DW), .DEPTH(4), .PACKET_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tready(b_s_tready),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .m_tvalid(b_m_tvalid),
        .m_tready(m_tready), .m_tdata(b_m_tdata), .m_tlast(b_m_tlast),
        .count(b_count), .pkt_count(b_pkt));

    function automatic int depth_of(int i);
        return (i == 1) ? 8 : 4;
    endfunction

    function automatic bit pm_of(int i);
        return i != 0;
    endfunction

    function automatic q_t get_q(int i);
        case (i)
            0:       return q0;
            1:       return q1;
            default: return q2;
        endcase
    endfunction

    task automatic set_q(input int i, input q_t q);
        case (i)
            0:       q0 = q;
            1:       q1 = q;
            default: q2 = q;
        endcase
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) rel[i] = 1'b0;
    endtask

    // Expected outputs from the model; data/last are zeroed when not valid
    function automatic obs_t model_exp(int i);
        q_t   q = get_q(i);
        int   n = q.size();
        int   p = 0;
        obs_t e = '0;
        foreach (q[k]) if (q[k][DW]) p++;
        e.valid = (n > 0) && (!pm_of(i) || p > 0 || n == depth_of(i) || rel[i]);
        if (e.valid) begin
            e.data = q[0][DW-1:0];
            e.last = q[0][DW];
        end
        e.ready = !reset && (n < depth_of(i));
        e.cnt   = 5'(n);
        e.pkt   = 5'(p);
        return e;
    endfunction

    function automatic obs_t get_obs(int i);
        obs_t o = '0;
        case (i)
            0: begin
                o.valid = w_m_tvalid; o.data = w_m_tdata; o.last = w_m_tlast;
                o.ready = w_s_tready; o.cnt = 5'(w_count); o.pkt = 5'(w_pkt);
            end
            1: begin
                o.valid = a_m_tvalid; o.data = a_m_tdata; o.last = a_m_tlast;
                o.ready = a_s_tready; o.cnt = 5'(a_count); o.pkt = 5'(a_pkt);
            end
            default: begin
                o.valid = b_m_tvalid; o.data = b_m_tdata; o.last = b_m_tlast;
                o.ready = b_s_tready; o.cnt = 5'(b_count); o.pkt = 5'(b_pkt);
            end
        endcase
        if (o.valid !== 1'b1) begin
            o.data = '0;
            o.last = 1'b0;
        end
        return o;
    endfunction

    // Advance the model by one clock edge using the inputs held at that edge
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            q_t   q = get_q(i);
            obs_t e = model_exp(i);
            bit   wr;
            bit   rd;
            if (reset) begin
                q.delete();
                rel[i] = 1'b0;
            end else begin
                wr = s_tvalid && e.ready;
                rd = e.valid && m_tready;
                if (pm_of(i)) begin
                    if (rd && e.last) rel[i] = 1'b0;
                    else if (q.size() == depth_of(i)) rel[i] = 1'b1;
                end
                if (rd) void'(q.pop_front());
                if (wr) q.push_back({s_tlast, s_tdata});
            end
            set_q(i, q);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        reset    = 1'b1;
        clear_model();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        reset    = 1'b1;
        clear_model();
        tick();
        for (int i = 0; i < 3; i++) begin
            obs_t o = get_obs(i);
            total++;
            if (o.valid !== 1'b0 || o.ready !== 1'b0 || o.cnt !== 5'd0 || o.pkt !== 5'd0) begin
                bad++;
                $display("FAIL reset_hold inst%0d: actual v=%b r=%b c=%0d p=%0d required 0 0 0 0",
                         i, o.valid, o.ready, o.cnt, o.pkt);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            obs_t o = get_obs(i);
            total++;
            if (o.ready !== 1'b1 || o.valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_release inst%0d: actual ready=%b valid=%b required 1 0",
                         i, o.ready, o.valid);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_word_stream();
        apply_reset();
        m_tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_tvalid = (k < 3);
            s_tdata  = 16'(k + 1);
            s_tlast  = (k == 2);
            tick();
            for (int i = 0; i < 3; i++) begin
                obs_t o = get_obs(i);
                obs_t e = model_exp(i);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL word_stream inst%0d k=%0d: actual %h required %h", i, k, o, e);
                end
            end
            total++;
            if (k < 3) begin
                if (w_m_tvalid !== 1'b1 || w_m_tdata !== 16'(k + 1) ||
                    w_m_tlast !== (k == 2) || w_count !== 3'd1) begin
                    bad++;
                    $display("FAIL word_stream_out k=%0d: actual v=%b d=%0d l=%b c=%0d required 1 %0d %b 1",
                             k, w_m_tvalid, w_m_tdata, w_m_tlast, w_count, k + 1, k == 2);
                end
            end else if (w_m_tvalid !== 1'b0 || w_count !== 3'd0) begin
                bad++;
                $display("FAIL word_stream_idle k=%0d: actual v=%b c=%0d required 0 0",
                         k, w_m_tvalid, w_count);
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_d [3] = '{12, 13, 14};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'(10 + k);
            s_tlast  = (k == 4);
            if (k == 4) m_tready = 1'b0;
            tick();
            for (int i = 0; i < 3; i++) begin
                obs_t o = get_obs(i);
                obs_t e = model_exp(i);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL backpressure_fill inst%0d k=%0d: actual %h required %h", i, k, o, e);
                end
            end
        end
        total++;
        if (w_count !== 3'd4 || w_s_tready !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_full: actual c=%0d r=%b required 4 0", w_count, w_s_tready);
        end
        m_tready = 1'b1;
        tick();
        total++;
        if (w_count !== 3'd3 || w_s_tready !== 1'b1 || w_m_tdata !== 16'd11) begin
            bad++;
            $display("FAIL backpressure_first_read: actual c=%0d r=%b d=%0d required 3 1 11",
                     w_count, w_s_tready, w_m_tdata);
        end
        tick();
        s_tvalid = 1'b0;
        total++;
        if (w_count !== 3'd3) begin
            bad++;
            $display("FAIL backpressure_accept: actual c=%0d required 3", w_count);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (w_m_tvalid !== 1'b1 || w_m_tdata !== 16'(exp_d[k]) || w_m_tlast !== (k == 2)) begin
                bad++;
                $display("FAIL backpressure_drain k=%0d: actual v=%b d=%0d l=%b required 1 %0d %b",
                         k, w_m_tvalid, w_m_tdata, w_m_tlast, exp_d[k], k == 2);
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                obs_t o = get_obs(i);
                obs_t e = model_exp(i);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL backpressure_model inst%0d k=%0d: actual %h required %h", i, k, o, e);
                end
            end
        end
    endtask

    task automatic test_packet_sf();
        apply_reset();
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'(20 + k);
            s_tlast  = (k == 2);
            tick();
            total++;
            if (a_m_tvalid !== (k == 2) || (k == 2 && a_pkt !== 4'd1)) begin
                bad++;
                $display("FAIL packet_hold k=%0d: actual v=%b p=%0d required %b", k, a_m_tvalid, a_pkt, k == 2);
            end
        end
        s_tvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (a_m_tvalid !== 1'b1 || a_m_tdata !== 16'(20 + k) || a_pkt !== 4'd1) begin
                bad++;
                $display("FAIL packet_emit k=%0d: actual v=%b d=%0d p=%0d required 1 %0d 1",
                         k, a_m_tvalid, a_m_tdata, a_pkt, 20 + k);
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                obs_t o = get_obs(i);
                obs_t e = model_exp(i);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL packet_model inst%0d k=%0d: actual %h required %h", i, k, o, e);
                end
            end
        end
        total++;
        if (a_pkt !== 4'd0 || a_count !== 4'd0 || a_m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL packet_done: actual p=%0d c=%0d v=%b required 0 0 0", a_pkt, a_count, a_m_tvalid);
        end
    endtask

    task automatic test_cut_through();
        int          idx = 0;
        logic [DW:0] got[$];
        bit          acc;
        apply_reset();
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
            s_tvalid = (idx < 6);
            s_tdata  = 16'(30 + idx);
            s_tlast  = (idx == 5);
            acc = s_tvalid && model_exp(2).ready;
            if (b_m_tvalid === 1'b1) got.push_back({b_m_tlast, b_m_tdata});
            tick();
            if (acc) idx++;
            for (int i = 0; i < 3; i++) begin
                obs_t o = get_obs(i);
                obs_t e = model_exp(i);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL cut_through_model inst%0d cyc=%0d: actual %h required %h", i, cyc, o, e);
                end
            end
        end
        total++;
        if (got.size() != 6) begin
            bad++;
            $display("FAIL cut_through_len: actual %0d words required 6", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            total++;
            if (got[k] !== {(k == 5), 16'(30 + k)}) begin
                bad++;
                $display("FAIL cut_through_word k=%0d: actual %h required %h", k, got[k], {(k == 5), 16'(30 + k)});
            end
        end
        // A lone non-tlast word must be held again once the latch has cleared
        s_tvalid = 1'b1;
        s_tdata  = 16'd99;
        s_tlast  = 1'b0;
        tick();
        s_tvalid = 1'b0;
        tick();
        total++;
        if (b_m_tvalid !== 1'b0 || b_count !== 3'd1) begin
            bad++;
            $display("FAIL cut_through_latch_clear: actual v=%b c=%0d required 0 1", b_m_tvalid, b_count);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'(40 + k);
            s_tlast  = 1'b0;
            tick();
        end
        m_tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'(42 + k);
            s_tlast  = (k % 3 == 2);
            tick();
            total++;
            if (w_count !== 3'd2 || w_m_tdata !== 16'(41 + k)) begin
                bad++;
                $display("FAIL back_to_back k=%0d: actual c=%0d d=%0d required 2 %0d", k, w_count, w_m_tdata, 41 + k);
            end
            for (int i = 0; i < 3; i++) begin
                obs_t o = get_obs(i);
                obs_t e = model_exp(i);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL back_to_back_model inst%0d k=%0d: actual %h required %h", i, k, o, e);
                end
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] got[$];
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'(50 + k);
            s_tlast  = 1'b0;
            tick();
        end
        s_tvalid = 1'b0;
        total++;
        if (w_count !== 3'd3) begin
            bad++;
            $display("FAIL reset_mid_pre: actual c=%0d required 3", w_count);
        end
        #2;
        reset = 1'b1;
        clear_model();
        #1;
        for (int i = 0; i < 3; i++) begin
            obs_t o = get_obs(i);
            total++;
            if (o.valid !== 1'b0 || o.cnt !== 5'd0 || o.pkt !== 5'd0 || o.ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_async inst%0d: actual v=%b c=%0d p=%0d r=%b required 0 0 0 0",
                         i, o.valid, o.cnt, o.pkt, o.ready);
            end
        end
        tick();
        reset    = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s_tvalid = (k < 2);
            s_tdata  = 16'(60 + k);
            s_tlast  = (k == 1);
            if (w_m_tvalid === 1'b1) got.push_back(w_m_tdata);
            tick();
            for (int i = 0; i < 3; i++) begin
                obs_t o = get_obs(i);
                obs_t e = model_exp(i);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL reset_mid_model inst%0d k=%0d: actual %h required %h", i, k, o, e);
                end
            end
        end
        total++;
        if (got.size() != 2 || got[0] !== 16'd60 || got[1] !== 16'd61) begin
            bad++;
            $display("FAIL reset_mid_packet: actual %0d words (first %0d) required 2 words 60 61",
                     got.size(), (got.size() > 0) ? got[0] : 16'd0);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            s_tvalid = ($urandom % 4) != 0;
            s_tdata  = 16'($urandom);
            s_tlast  = ($urandom % 4) == 0;
            m_tready = (k % 64 < 16) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
            tick();
            for (int i = 0; i < 3; i++) begin
                obs_t o = get_obs(i);
                obs_t e = model_exp(i);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL random inst%0d k=%0d: actual %h required %h", i, k, o, e);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        test_reset();
        test_word_stream();
        test_backpressure();
        test_packet_sf();
        test_cut_through();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
